map_ram_arbiter: RTL
====================

// Module: map_ram_arbiter
// PURPOSE
//  Shares the single-port 1200x8 tile-map RAM between two requesters: the display tile fetcher
//  (read-only, latency-critical) and the CPU/Avalon slave (read/write, stallable). Issues at most one
//  RAM access per cycle, routes 1-cycle-latency read data back to its owner, and bounds CPU starvation.
//  Sits between the VGA tile renderer, the HPS bridge and the map RAM instance.
// PARAMETERS
//  DEPTH       1200   valid words; addresses >= DEPTH are out of range
//  ADDR_W      11     address width, all ports
//  DATA_W      8      data width, all ports
//  MAX_WAIT    4      consecutive stalled CPU cycles before the CPU is forced a slot (>=1)
//  CLEAR_VALUE 8'h00  fill value for the clear engine
// PORTS
//  clk            in   1       single clock
//  reset          in   1       synchronous, active-high
//  disp_req       in   1       display read request, held until disp_ack
//  disp_addr      in   ADDR_W  display read address
//  disp_ack       out  1       display request accepted this cycle
//  disp_rdata     out  DATA_W  display read data
//  disp_rvalid    out  1       disp_rdata valid (1 cycle after disp_ack)
//  cpu_read       in   1       CPU read command
//  cpu_write      in   1       CPU write command (read and write never both high)
//  cpu_addr       in   ADDR_W  CPU address
//  cpu_wdata      in   DATA_W  CPU write data
//  cpu_waitrequest out 1       command not accepted; CPU holds it
//  cpu_rdata      out  DATA_W  CPU read data
//  cpu_rvalid     out  1       cpu_rdata valid (1 cycle after accepted read)
//  clear_start    in   1       pulse: fill whole map with CLEAR_VALUE
//  clear_busy     out  1       clear sweep in progress
//  ram_address    out  ADDR_W  to RAM
//  ram_chipselect out  1       to RAM
//  ram_write      out  1       to RAM (RAM write qualifier)
//  ram_writedata  out  DATA_W  to RAM
//  ram_clken      out  1       to RAM, constant 1
//  ram_readdata   in   DATA_W  from RAM, valid 1 cycle after address
// BEHAVIOUR
//  - Grant is combinational on current requests; ram_* driven combinationally from the grant.
//  - Priority: display > CPU, except when starve_cnt==MAX_WAIT: CPU wins, disp_ack=0 that cycle.
//  - starve_cnt: +1 each cycle CPU requests and is not granted; cleared on CPU grant or no request.
//  - cpu_waitrequest = (cpu_read|cpu_write) & ~cpu_grant; command accepted when it is low.
//  - Registered owner tag {NONE,DISP,CPU,OOR} selects ram_readdata on the next cycle; the rvalid of the
//    owner pulses exactly 1 cycle; rdata is held until the next rvalid of that port.
//  - Out of range (addr >= DEPTH): CPU write accepted and dropped (ram_write=0); CPU/display read
//    accepted, returns 8'h00 with rvalid at normal latency, ram_chipselect=0.
//  - Back-to-back: a new access may be granted every cycle; rvalids pipeline with no bubble.
//  - Clear engine FSM C_IDLE -> C_RUN on clear_start; C_RUN writes CLEAR_VALUE at clr_addr=0..DEPTH-1,
//    one word per cycle the display is not granted; clear owns the CPU slot (CPU stalled, starve_cnt
//    frozen at 0); after writing DEPTH-1 -> C_IDLE. clear_start in C_RUN ignored. clear_start in the
//    same cycle as a CPU command: that command is still arbitrated; sweep starts next cycle.
//  - Reset: starve_cnt=0, tag=NONE, FSM=C_IDLE, clr_addr=0; disp_rvalid=cpu_rvalid=0,
//    disp_rdata=cpu_rdata=0, clear_busy=0, disp_ack=0. A read in flight at reset produces no rvalid.
// CONFIGURATION
//  MAP_ARB_CLEAR_EN defined: clear engine built as above.
//  Not defined: clear_start ignored, clear_busy tied 0, no clear FSM/counter logic.
// TESTING
//  1 CPU write 0x5A to 0x010, then read 0x010, no display traffic -> waitrequest 0 both; rvalid 1
//    cycle after read, cpu_rdata=0x5A.
//  2 disp_req held high continuously + CPU read -> CPU waitrequest high 4 cycles, granted 5th; that
//    cycle disp_ack=0; display resumes next cycle.
//  3 Display reads addresses 0..3 back-to-back -> disp_ack every cycle, disp_rvalid 4 consecutive
//    cycles, data in address order.
//  4 CPU write 0xFF to 1200, then read 1200 -> no RAM write; cpu_rdata=0x00, rvalid at normal latency.
//  5 (MAP_ARB_CLEAR_EN) clear_start, no display -> clear_busy 1200 cycles; reads of 0 and 1199 = 0x00;
//    CPU command during sweep waits until clear_busy falls.
//  6 reset asserted 1 cycle after an accepted CPU read -> no cpu_rvalid; all outputs at reset values.

Source files
------------

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port 1200x8 tile-map RAM between the
// display tile fetcher (read-only, highest priority) and the CPU/Avalon slave
// (read/write, stallable, bounded starvation). An optional clear engine fills
// the map with CLEAR_VALUE; it is built only when MAP_ARB_CLEAR_EN is defined.
//
// Clear FSM states:
//   state  | meaning
//   C_IDLE | no sweep; CPU arbitrates normally
//   C_RUN  | sweeping clr_addr 0..DEPTH-1, clear owns the CPU slot
module map_ram_arbiter #(
  parameter int                DEPTH       = 1200,
  parameter int                ADDR_W      = 11,
  parameter int                DATA_W      = 8,
  parameter int                MAX_WAIT    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  // Owner of the read data returning next cycle; OOR reads return zero and
  // oor_disp remembers which port the OOR read belongs to.
  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU, T_OOR} tag_t;

  tag_t              tag_q, tag_d;
  logic              oor_disp_q, oor_disp_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] disp_hold_q, cpu_hold_q;

  logic              cpu_req, force_cpu;
  logic              disp_grant, cpu_grant, clr_grant;
  logic              disp_in, cpu_in;
  logic [ADDR_W-1:0] clr_addr;

`ifdef MAP_ARB_CLEAR_EN
  typedef enum logic {C_IDLE, C_RUN} clr_state_t;

  clr_state_t        clr_state_q, clr_state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // Clear FSM state and sweep address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q <= C_IDLE;
      clr_addr_q  <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  // Clear FSM next state: advance one word per cycle the sweep owns the RAM.
  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    case (clr_state_q)
      C_IDLE: begin
        if (clear_start) clr_state_d = C_RUN;
      end
      C_RUN: begin
        if (clr_grant) begin
          if (clr_addr_q == LAST_A) begin
            clr_state_d = C_IDLE;
            clr_addr_d  = '0;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: clr_state_d = C_IDLE;
    endcase
  end

  assign clear_busy = (clr_state_q == C_RUN);
  assign clr_addr   = clr_addr_q;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign clear_busy         = 1'b0;
  assign clr_addr           = '0;
`endif

  assign cpu_req   = cpu_read | cpu_write;
  assign disp_in   = (disp_addr < DEPTH_A);
  assign cpu_in    = (cpu_addr < DEPTH_A);
  assign force_cpu = cpu_req & (starve_q == SW'(MAX_WAIT)) & ~clear_busy;

  // Grants are held off during reset so ack/accept read as idle in that cycle.
  assign disp_grant = ~reset & disp_req & ~force_cpu;
  assign clr_grant  = ~reset & clear_busy & ~disp_grant;
  assign cpu_grant  = ~reset & cpu_req & ~disp_grant & ~clear_busy;

  assign disp_ack        = disp_grant;
  assign cpu_waitrequest = cpu_req & ~cpu_grant;
  assign ram_clken       = 1'b1;

  // RAM port mux, next owner tag and starvation counter from the current grant.
  always_comb begin
    ram_address    = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    tag_d          = T_NONE;
    oor_disp_d     = oor_disp_q;
    if (disp_grant) begin
      ram_address    = disp_addr;
      ram_chipselect = disp_in;
      tag_d          = disp_in ? T_DISP : T_OOR;
      oor_disp_d     = 1'b1;
    end else if (cpu_grant) begin
      ram_address    = cpu_addr;
      ram_chipselect = cpu_in;
      ram_write      = cpu_write & cpu_in;
      ram_writedata  = cpu_wdata;
      if (cpu_read) begin
        tag_d      = cpu_in ? T_CPU : T_OOR;
        oor_disp_d = 1'b0;
      end
    end else if (clr_grant) begin
      ram_address    = clr_addr;
      ram_chipselect = 1'b1;
      ram_write      = 1'b1;
      ram_writedata  = CLEAR_VALUE;
    end

    if (clear_busy || !cpu_req || cpu_grant) starve_d = '0;
    else                                     starve_d = starve_q + 1'b1;
  end

  // Return path: the rvalid of the tagged owner pulses; rdata holds otherwise.
  always_comb begin
    disp_rvalid = ~reset & ((tag_q == T_DISP) | ((tag_q == T_OOR) & oor_disp_q));
    cpu_rvalid  = ~reset & ((tag_q == T_CPU) | ((tag_q == T_OOR) & ~oor_disp_q));
    disp_rdata  = disp_hold_q;
    cpu_rdata   = cpu_hold_q;
    if (disp_rvalid) disp_rdata = (tag_q == T_DISP) ? ram_readdata : '0;
    if (cpu_rvalid)  cpu_rdata  = (tag_q == T_CPU) ? ram_readdata : '0;
  end

  // Arbiter state: owner tag, starvation counter and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= T_NONE;
      oor_disp_q  <= 1'b0;
      starve_q    <= '0;
      disp_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      oor_disp_q  <= oor_disp_d;
      starve_q    <= starve_d;
      disp_hold_q <= disp_rdata;
      cpu_hold_q  <= cpu_rdata;
    end
  end

endmodule
